// File: rtl/mem_pkg.sv
// Shared definitions for the stack/data memory controller: operation codes,
// FSM state encoding, SP update commands and stack geometry defaults.
package mem_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDD  = 4'd1;
    localparam logic [3:0] OP_STD  = 4'd2;
    localparam logic [3:0] OP_PUSH = 4'd3;
    localparam logic [3:0] OP_POP  = 4'd4;
    localparam logic [3:0] OP_CALL = 4'd5;
    localparam logic [3:0] OP_RET  = 4'd6;
    localparam logic [3:0] OP_INT  = 4'd7;
    localparam logic [3:0] OP_RTI  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_INT_FLAGS = 2'd1,
        ST_RTI_PC    = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SP_HOLD = 3'd0,
        SP_INC2 = 3'd1,
        SP_DEC2 = 3'd2,
        SP_INC4 = 3'd3,
        SP_DEC4 = 3'd4
    } sp_op_t;

    localparam int DEFAULT_NUM_OF_REGISTER = 11;
    localparam int DEFAULT_STACK_FLOOR     = 1024;

    // Empty-stack SP: the top 32-bit slot of a 2**n word memory.
    function automatic logic [31:0] reset_sp(input int n);
        return (32'd1 << n) - 32'd2;
    endfunction

endpackage

// File: rtl/stack_pointer_unit.sv
// Stack pointer register with +-2/+-4 update and full/empty detection.
// The stack descends; SP addresses the next free 32-bit slot.
module stack_pointer_unit
    import mem_pkg::*;
#(
    parameter int address_width   = 32,
    parameter int num_of_register = DEFAULT_NUM_OF_REGISTER,
    parameter int stack_floor     = DEFAULT_STACK_FLOOR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               i_sp_op,
    output logic [address_width-1:0] o_sp,
    output logic [address_width-1:0] o_sp_p2,
    output logic                     o_push_full,
    output logic                     o_int_full,
    output logic                     o_pop_empty,
    output logic                     o_rti_empty
);

    localparam logic [address_width-1:0] RESET_SP  = address_width'(reset_sp(num_of_register));
    localparam logic [address_width-1:0] FLOOR     = address_width'(stack_floor);
    localparam logic [address_width-1:0] TWO       = address_width'(2);
    localparam logic [address_width-1:0] FOUR      = address_width'(4);
    localparam logic [address_width-1:0] RTI_LIMIT = RESET_SP - FOUR;

    logic [address_width-1:0] r_sp;

    // SP register: modulo arithmetic, one update per accepted stack op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp <= RESET_SP;
        end else begin
            case (i_sp_op)
                SP_INC2: r_sp <= r_sp + TWO;
                SP_DEC2: r_sp <= r_sp - TWO;
                SP_INC4: r_sp <= r_sp + FOUR;
                SP_DEC4: r_sp <= r_sp - FOUR;
                default: r_sp <= r_sp;
            endcase
        end
    end

    assign o_sp        = r_sp;
    assign o_sp_p2     = r_sp + TWO;
    // INT needs room for two slots, RTI needs two occupied slots.
    assign o_push_full = r_sp < FLOOR;
    assign o_int_full  = (r_sp - TWO) < FLOOR;
    assign o_pop_empty = r_sp == RESET_SP;
    assign o_rti_empty = r_sp > RTI_LIMIT;

endmodule

// File: rtl/stack_mem_controller.sv
// MEM-stage memory initiator: decodes LDD/STD/PUSH/POP/CALL/RET/INT/RTI into
// memory accesses, owns SP, and sequences the two-access INT/RTI ops.
module stack_mem_controller
    import mem_pkg::*;
#(
    parameter int data_width      = 16,
    parameter int address_width   = 32,
    parameter int num_of_register = DEFAULT_NUM_OF_REGISTER,
    parameter int stack_floor     = DEFAULT_STACK_FLOOR
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      op_valid,
    input  logic [3:0]                op_code,
    input  logic [address_width-1:0]  ea,
    input  logic [2*data_width-1:0]   wdata,
    input  logic [2*data_width-1:0]   pc_in,
    input  logic [2:0]                flags_in,
    output logic                      busy,
    output logic                      mem_write_enable,
    output logic                      mem_read_enable,
    output logic [address_width-1:0]  mem_address,
    output logic [2*data_width-1:0]   mem_write_data,
    input  logic [2*data_width-1:0]   mem_read_data,
    output logic [2*data_width-1:0]   rd_data,
    output logic                      rd_valid,
    output logic [2*data_width-1:0]   pc_out,
    output logic                      pc_load,
    output logic [2:0]                flags_out,
    output logic                      flags_load,
    output logic [address_width-1:0]  sp,
    output logic                      stack_err
);

    localparam int WW = 2 * data_width;

    state_t                   r_state;
    logic [2:0]               r_int_flags;
    logic [2:0]               r_rti_flags;
    logic [WW-1:0]            r_rd_data;
    logic                     r_rd_valid;
    logic [WW-1:0]            r_pc_out;
    logic                     r_pc_load;
    logic [2:0]               r_flags_out;
    logic                     r_flags_load;
    logic                     r_stack_err;

    logic [address_width-1:0] w_sp;
    logic [address_width-1:0] w_sp_p2;
    logic                     w_push_full;
    logic                     w_int_full;
    logic                     w_pop_empty;
    logic                     w_rti_empty;
    sp_op_t                   w_sp_op;
    logic                     w_we;
    logic                     w_re;
    logic [address_width-1:0] w_addr;
    logic [WW-1:0]            w_wdata;
    logic                     w_rd_event;
    logic                     w_ret_event;
    logic                     w_start_int;
    logic                     w_start_rti;
    logic                     w_reject;

    stack_pointer_unit #(
        .address_width   (address_width),
        .num_of_register (num_of_register),
        .stack_floor     (stack_floor)
    ) u_sp (
        .clk         (clk),
        .rst         (rst),
        .i_sp_op     (w_sp_op),
        .o_sp        (w_sp),
        .o_sp_p2     (w_sp_p2),
        .o_push_full (w_push_full),
        .o_int_full  (w_int_full),
        .o_pop_empty (w_pop_empty),
        .o_rti_empty (w_rti_empty)
    );

    // Same-cycle memory drive and op decode; INT/RTI move SP by 4 at accept,
    // so the second access is addressed relative to the already-updated SP.
    always_comb begin
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_addr      = '0;
        w_wdata     = '0;
        w_sp_op     = SP_HOLD;
        w_rd_event  = 1'b0;
        w_ret_event = 1'b0;
        w_start_int = 1'b0;
        w_start_rti = 1'b0;
        w_reject    = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            OP_NOP: ;
                            OP_LDD: begin
                                w_re       = 1'b1;
                                w_addr     = ea;
                                w_rd_event = 1'b1;
                            end
                            OP_STD: begin
                                w_we    = 1'b1;
                                w_addr  = ea;
                                w_wdata = wdata;
                            end
                            OP_PUSH, OP_CALL: begin
                                if (w_push_full) begin
                                    w_reject = 1'b1;
                                end else begin
                                    w_we    = 1'b1;
                                    w_addr  = w_sp;
                                    w_wdata = (op_code == OP_PUSH) ? wdata : pc_in;
                                    w_sp_op = SP_DEC2;
                                end
                            end
                            OP_POP, OP_RET: begin
                                if (w_pop_empty) begin
                                    w_reject = 1'b1;
                                end else begin
                                    w_re        = 1'b1;
                                    w_addr      = w_sp_p2;
                                    w_sp_op     = SP_INC2;
                                    w_rd_event  = (op_code == OP_POP);
                                    w_ret_event = (op_code == OP_RET);
                                end
                            end
                            OP_INT: begin
                                if (w_int_full) begin
                                    w_reject = 1'b1;
                                end else begin
                                    w_we        = 1'b1;
                                    w_addr      = w_sp;
                                    w_wdata     = pc_in;
                                    w_sp_op     = SP_DEC4;
                                    w_start_int = 1'b1;
                                end
                            end
                            OP_RTI: begin
                                if (w_rti_empty) begin
                                    w_reject = 1'b1;
                                end else begin
                                    w_re        = 1'b1;
                                    w_addr      = w_sp_p2;
                                    w_sp_op     = SP_INC4;
                                    w_start_rti = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_INT_FLAGS: begin
                    w_we    = 1'b1;
                    w_addr  = w_sp_p2;
                    w_wdata = {{(WW-3){1'b0}}, r_int_flags};
                end
                ST_RTI_PC: begin
                    w_re   = 1'b1;
                    w_addr = w_sp;
                end
                default: ;
            endcase
        end
    end

    // Sequencing FSM with registered results and one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_int_flags  <= '0;
            r_rti_flags  <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_pc_out     <= '0;
            r_pc_load    <= 1'b0;
            r_flags_out  <= '0;
            r_flags_load <= 1'b0;
            r_stack_err  <= 1'b0;
        end else begin
            r_rd_valid   <= 1'b0;
            r_pc_load    <= 1'b0;
            r_flags_load <= 1'b0;
            r_stack_err  <= w_reject;
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_event) begin
                        r_rd_data  <= mem_read_data;
                        r_rd_valid <= 1'b1;
                    end
                    if (w_ret_event) begin
                        r_pc_out  <= mem_read_data;
                        r_pc_load <= 1'b1;
                    end
                    if (w_start_int) begin
                        r_int_flags <= flags_in;
                        r_state     <= ST_INT_FLAGS;
                    end
                    if (w_start_rti) begin
                        r_rti_flags <= mem_read_data[2:0];
                        r_state     <= ST_RTI_PC;
                    end
                end
                ST_INT_FLAGS: r_state <= ST_IDLE;
                ST_RTI_PC: begin
                    r_pc_out     <= mem_read_data;
                    r_flags_out  <= r_rti_flags;
                    r_pc_load    <= 1'b1;
                    r_flags_load <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy             = (r_state != ST_IDLE);
    assign mem_write_enable = w_we;
    assign mem_read_enable  = w_re;
    assign mem_address      = w_addr;
    assign mem_write_data   = w_wdata;
    assign rd_data          = r_rd_data;
    assign rd_valid         = r_rd_valid;
    assign pc_out           = r_pc_out;
    assign pc_load          = r_pc_load;
    assign flags_out        = r_flags_out;
    assign flags_load       = r_flags_load;
    assign sp               = w_sp;
    assign stack_err        = r_stack_err;

endmodule

// File: tb/tb_stack_mem_controller.sv
// Bench for stack_mem_controller: directed scenarios plus a randomized run
// checked against a queue-based stack model and a data-memory map.
module tb_stack_mem_controller;

    localparam logic [3:0] NOP = 4'd0, LDD = 4'd1, STD = 4'd2, PUSH = 4'd3, POP = 4'd4,
                           CALL = 4'd5, RET = 4'd6, INT = 4'd7, RTI = 4'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [3:0]  op_code = 4'd0;
    logic [31:0] ea = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] pc_in = 32'd0;
    logic [2:0]  flags_in = 3'd0;
    logic        busy, mem_write_enable, mem_read_enable;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic [31:0] rd_data, pc_out, sp;
    logic        rd_valid, pc_load, flags_load, stack_err;
    logic [2:0]  flags_out;

    logic [31:0] tbmem [0:2047] = '{default: 32'd0};
    logic [10:0] w_idx;
    int          wr_count = 0;

    int n_vec = 0;
    int n_err = 0;

    // Values observed before the edge (c_) and after the edge (q_).
    logic        c_we, c_re, c_busy;
    logic [31:0] c_addr, c_wd;
    logic        q_rd_valid, q_pc_load, q_fl_load, q_err, q_busy;
    logic [31:0] q_rd_data, q_pc_out, q_sp;
    logic [2:0]  q_fl_out;

    stack_mem_controller dut (
        .clk              (clk),
        .rst              (rst),
        .op_valid         (op_valid),
        .op_code          (op_code),
        .ea               (ea),
        .wdata            (wdata),
        .pc_in            (pc_in),
        .flags_in         (flags_in),
        .busy             (busy),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .pc_out           (pc_out),
        .pc_load          (pc_load),
        .flags_out        (flags_out),
        .flags_load       (flags_load),
        .sp               (sp),
        .stack_err        (stack_err)
    );

    always #5 clk = ~clk;

    assign w_idx         = 11'(mem_address % 32'd2048);
    assign mem_read_data = tbmem[w_idx];

    always @(posedge clk) begin
        if (mem_write_enable) begin
            tbmem[w_idx] <= mem_write_data;
            wr_count     <= wr_count + 1;
        end
    end

    task automatic tick(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] pc, input logic [2:0] fl,
                        input logic r);
        @(negedge clk);
        rst = r; op_valid = v; op_code = op; ea = a; wdata = wd; pc_in = pc; flags_in = fl;
        #1;
        c_we = mem_write_enable; c_re = mem_read_enable; c_addr = mem_address;
        c_wd = mem_write_data; c_busy = busy;
        @(posedge clk);
        #1;
        q_rd_valid = rd_valid; q_rd_data = rd_data; q_pc_load = pc_load; q_pc_out = pc_out;
        q_fl_load = flags_load; q_fl_out = flags_out; q_err = stack_err; q_sp = sp; q_busy = busy;
    endtask

    task automatic idle();
        tick(1'b0, NOP, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b0, NOP, 32'd0, 32'd0, 32'd0, 3'd0, 1'b1);
    endtask

    task automatic test_reset();
        tick(1'b1, PUSH, 32'd0, 32'h11111111, 32'd0, 3'd0, 1'b1);
        n_vec++; if (c_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %0b want 0", c_we); end
        tick(1'b1, POP, 32'd0, 32'd0, 32'd0, 3'd0, 1'b1);
        n_vec++; if (c_re !== 1'b0) begin n_err++; $display("FAIL rst_re: got %0b want 0", c_re); end
        n_vec++; if (q_sp !== 32'd2046) begin n_err++; $display("FAIL rst_sp: got %0d want 2046", q_sp); end
        n_vec++; if (q_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", q_busy); end
        n_vec++; if ({q_rd_valid, q_pc_load, q_fl_load, q_err} !== 4'b0) begin
            n_err++; $display("FAIL rst_pulses: got %b want 0000", {q_rd_valid, q_pc_load, q_fl_load, q_err}); end
        n_vec++; if ({q_rd_data, q_pc_out, q_fl_out} !== 67'd0) begin
            n_err++; $display("FAIL rst_regs: got %h/%h/%h want 0", q_rd_data, q_pc_out, q_fl_out); end
        idle();
        n_vec++; if ({c_we, c_re, c_addr, c_wd} !== 66'd0) begin
            n_err++; $display("FAIL idle_drive: we=%0b re=%0b addr=%h wd=%h want 0", c_we, c_re, c_addr, c_wd); end
    endtask

    task automatic test_push_pop();
        tick(1'b1, PUSH, 32'd0, 32'hDEADBEEF, 32'd0, 3'd0, 1'b0);
        n_vec++; if ({c_we, c_re} !== 2'b10) begin n_err++; $display("FAIL push_en: got %b want 10", {c_we, c_re}); end
        n_vec++; if (c_addr !== 32'd2046) begin n_err++; $display("FAIL push_addr: got %0d want 2046", c_addr); end
        n_vec++; if (c_wd !== 32'hDEADBEEF) begin n_err++; $display("FAIL push_data: got %h want deadbeef", c_wd); end
        n_vec++; if (q_sp !== 32'd2044) begin n_err++; $display("FAIL push_sp: got %0d want 2044", q_sp); end
        tick(1'b1, POP, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0);
        n_vec++; if ({c_we, c_re} !== 2'b01) begin n_err++; $display("FAIL pop_en: got %b want 01", {c_we, c_re}); end
        n_vec++; if (c_addr !== 32'd2046) begin n_err++; $display("FAIL pop_addr: got %0d want 2046", c_addr); end
        n_vec++; if (q_rd_valid !== 1'b1) begin n_err++; $display("FAIL pop_valid: got %0b want 1", q_rd_valid); end
        n_vec++; if (q_rd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL pop_data: got %h want deadbeef", q_rd_data); end
        n_vec++; if (q_sp !== 32'd2046) begin n_err++; $display("FAIL pop_sp: got %0d want 2046", q_sp); end
        idle();
        n_vec++; if (q_rd_valid !== 1'b0) begin n_err++; $display("FAIL pop_pulse: got %0b want 0", q_rd_valid); end
    endtask

    task automatic test_std_ldd();
        tick(1'b1, STD, 32'h10, 32'h12345678, 32'd0, 3'd0, 1'b0);
        n_vec++; if ({c_we, c_addr, c_wd} !== {1'b1, 32'h10, 32'h12345678}) begin
            n_err++; $display("FAIL std: we=%0b addr=%h wd=%h want 1/10/12345678", c_we, c_addr, c_wd); end
        n_vec++; if (q_sp !== 32'd2046) begin n_err++; $display("FAIL std_sp: got %0d want 2046", q_sp); end
        tick(1'b1, LDD, 32'h10, 32'd0, 32'd0, 3'd0, 1'b0);
        n_vec++; if ({c_re, c_addr} !== {1'b1, 32'h10}) begin
            n_err++; $display("FAIL ldd_drive: re=%0b addr=%h want 1/10", c_re, c_addr); end
        n_vec++; if ({q_rd_valid, q_rd_data} !== {1'b1, 32'h12345678}) begin
            n_err++; $display("FAIL ldd_data: valid=%0b data=%h want 1/12345678", q_rd_valid, q_rd_data); end
        n_vec++; if (q_sp !== 32'd2046) begin n_err++; $display("FAIL ldd_sp: got %0d want 2046", q_sp); end
    endtask

    task automatic test_int_rti();
        tick(1'b1, INT, 32'd0, 32'd0, 32'h100, 3'b101, 1'b0);
        n_vec++; if ({c_we, c_addr, c_wd} !== {1'b1, 32'd2046, 32'h100}) begin
            n_err++; $display("FAIL int_pc: we=%0b addr=%0d wd=%h want 1/2046/100", c_we, c_addr, c_wd); end
        n_vec++; if (q_busy !== 1'b1) begin n_err++; $display("FAIL int_busy: got %0b want 1", q_busy); end
        idle();
        n_vec++; if ({c_we, c_addr, c_wd} !== {1'b1, 32'd2044, 32'h5}) begin
            n_err++; $display("FAIL int_flags: we=%0b addr=%0d wd=%h want 1/2044/5", c_we, c_addr, c_wd); end
        n_vec++; if ({q_busy, q_sp} !== {1'b0, 32'd2042}) begin
            n_err++; $display("FAIL int_end: busy=%0b sp=%0d want 0/2042", q_busy, q_sp); end
        tick(1'b1, RTI, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0);
        n_vec++; if ({c_re, c_addr} !== {1'b1, 32'd2044}) begin
            n_err++; $display("FAIL rti_first: re=%0b addr=%0d want 1/2044", c_re, c_addr); end
        n_vec++; if ({q_busy, q_pc_load, q_fl_load} !== 3'b100) begin
            n_err++; $display("FAIL rti_busy: got %b want 100", {q_busy, q_pc_load, q_fl_load}); end
        idle();
        n_vec++; if ({c_re, c_addr} !== {1'b1, 32'd2046}) begin
            n_err++; $display("FAIL rti_second: re=%0b addr=%0d want 1/2046", c_re, c_addr); end
        n_vec++; if ({q_pc_load, q_fl_load, q_pc_out, q_fl_out} !== {2'b11, 32'h100, 3'b101}) begin
            n_err++; $display("FAIL rti_result: loads=%b pc=%h fl=%b want 11/100/101",
                              {q_pc_load, q_fl_load}, q_pc_out, q_fl_out); end
        n_vec++; if (q_sp !== 32'd2046) begin n_err++; $display("FAIL rti_sp: got %0d want 2046", q_sp); end
        idle();
        n_vec++; if ({q_pc_load, q_fl_load} !== 2'b00) begin
            n_err++; $display("FAIL rti_pulse: got %b want 00", {q_pc_load, q_fl_load}); end
    endtask

    task automatic test_underflow();
        tick(1'b1, POP, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0);
        n_vec++; if ({c_we, c_re} !== 2'b00) begin n_err++; $display("FAIL uf_pop_en: got %b want 00", {c_we, c_re}); end
        n_vec++; if ({q_err, q_rd_valid, q_sp} !== {2'b10, 32'd2046}) begin
            n_err++; $display("FAIL uf_pop: err=%0b valid=%0b sp=%0d want 1/0/2046", q_err, q_rd_valid, q_sp); end
        tick(1'b1, RET, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0);
        n_vec++; if ({c_re, q_err, q_pc_load} !== 3'b010) begin
            n_err++; $display("FAIL uf_ret: re/err/load=%b want 010", {c_re, q_err, q_pc_load}); end
        tick(1'b1, PUSH, 32'd0, 32'h77, 32'd0, 3'd0, 1'b0);
        tick(1'b1, RTI, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0);
        n_vec++; if ({c_re, q_err, q_busy, q_sp} !== {3'b010, 32'd2044}) begin
            n_err++; $display("FAIL uf_rti: re=%0b err=%0b busy=%0b sp=%0d want 0/1/0/2044", c_re, q_err, q_busy, q_sp); end
        idle();
        n_vec++; if (q_err !== 1'b0) begin n_err++; $display("FAIL uf_pulse: got %0b want 0", q_err); end
        do_reset();
    endtask

    task automatic test_overflow();
        int misses = 0;
        for (int i = 0; i < 511; i++) begin
            tick(1'b1, PUSH, 32'd0, 32'(i), 32'd0, 3'd0, 1'b0);
            if (c_we !== 1'b1 || q_err !== 1'b0) misses++;
        end
        n_vec++; if (misses != 0 || q_sp !== 32'd1024) begin
            n_err++; $display("FAIL of_fill: misses=%0d sp=%0d want 0/1024", misses, q_sp); end
        tick(1'b1, INT, 32'd0, 32'd0, 32'h300, 3'd1, 1'b0);
        n_vec++; if ({c_we, q_err, q_busy, q_sp} !== {3'b010, 32'd1024}) begin
            n_err++; $display("FAIL of_int: we=%0b err=%0b busy=%0b sp=%0d want 0/1/0/1024", c_we, q_err, q_busy, q_sp); end
        tick(1'b1, PUSH, 32'd0, 32'd511, 32'd0, 3'd0, 1'b0);
        n_vec++; if ({c_we, c_addr, q_err, q_sp} !== {1'b1, 32'd1024, 1'b0, 32'd1022}) begin
            n_err++; $display("FAIL of_last: we=%0b addr=%0d err=%0b sp=%0d want 1/1024/0/1022", c_we, c_addr, q_err, q_sp); end
        tick(1'b1, CALL, 32'd0, 32'd0, 32'h999, 3'd0, 1'b0);
        n_vec++; if ({c_we, q_err, q_sp} !== {2'b01, 32'd1022}) begin
            n_err++; $display("FAIL of_reject: we=%0b err=%0b sp=%0d want 0/1/1022", c_we, q_err, q_sp); end
        misses = 0;
        for (int k = 0; k < 512; k++) begin
            tick(1'b1, POP, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0);
            if (q_rd_valid !== 1'b1 || q_rd_data !== 32'(511 - k)) misses++;
        end
        n_vec++; if (misses != 0 || q_sp !== 32'd2046) begin
            n_err++; $display("FAIL of_drain: misses=%0d sp=%0d want 0/2046", misses, q_sp); end
    endtask

    task automatic test_back_to_back();
        int w0;
        tick(1'b1, INT, 32'd0, 32'd0, 32'h40, 3'b010, 1'b0);
        w0 = wr_count;
        tick(1'b1, PUSH, 32'd0, 32'hAAAA5555, 32'd0, 3'd0, 1'b0);
        n_vec++; if ({c_busy, c_we, c_addr, c_wd} !== {2'b11, 32'd2044, 32'h2}) begin
            n_err++; $display("FAIL hold_ignored: busy=%0b we=%0b addr=%0d wd=%h want 1/1/2044/2",
                              c_busy, c_we, c_addr, c_wd); end
        n_vec++; if (q_sp !== 32'd2042) begin n_err++; $display("FAIL hold_sp: got %0d want 2042", q_sp); end
        tick(1'b1, PUSH, 32'd0, 32'hAAAA5555, 32'd0, 3'd0, 1'b0);
        n_vec++; if ({c_we, c_addr, c_wd, q_sp} !== {1'b1, 32'd2042, 32'hAAAA5555, 32'd2040}) begin
            n_err++; $display("FAIL hold_accept: we=%0b addr=%0d wd=%h sp=%0d want 1/2042/aaaa5555/2040",
                              c_we, c_addr, c_wd, q_sp); end
        idle();
        n_vec++; if (wr_count - w0 !== 2) begin
            n_err++; $display("FAIL hold_writes: got %0d want 2", wr_count - w0); end
        do_reset();
    endtask

    task automatic test_reset_mid_rti();
        tick(1'b1, INT, 32'd0, 32'd0, 32'h200, 3'b010, 1'b0);
        idle();
        tick(1'b1, RTI, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0);
        tick(1'b0, NOP, 32'd0, 32'd0, 32'd0, 3'd0, 1'b1);
        n_vec++; if ({c_we, c_re} !== 2'b00) begin n_err++; $display("FAIL rstmid_en: got %b want 00", {c_we, c_re}); end
        n_vec++; if ({q_pc_load, q_fl_load, q_busy, q_sp} !== {3'b000, 32'd2046}) begin
            n_err++; $display("FAIL rstmid_state: loads=%b busy=%0b sp=%0d want 00/0/2046",
                              {q_pc_load, q_fl_load}, q_busy, q_sp); end
        idle();
        n_vec++; if ({c_we, c_re, q_pc_load, q_pc_out} !== 35'd0) begin
            n_err++; $display("FAIL rstmid_after: we=%0b re=%0b load=%0b pc=%h want 0", c_we, c_re, q_pc_load, q_pc_out); end
    endtask

    task automatic test_random();
        logic [31:0] stk[$];
        logic [31:0] dm[logic [31:0]];
        int          pend;
        int          d;
        logic [31:0] p_addr, p_data, rti_pc, m_rd, m_pc, spv, tmp;
        logic [2:0]  rti_fl, m_fl;
        logic        v, r, e_we, e_re, e_busy, e_rdv, e_pcl, e_fll, e_err;
        logic [3:0]  op;
        logic [31:0] a, wd, pc, e_addr, e_wd, e_sp;
        logic [2:0]  fl;
        pend = 0; m_rd = 0; m_pc = 0; m_fl = 0; p_addr = 0; p_data = 0; rti_pc = 0; rti_fl = 0;
        for (int n = 0; n < 3000; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 15) < 13) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(9, 15));
            a  = 32'h100 + 32'($urandom_range(0, 255));
            wd = $urandom; pc = $urandom; fl = 3'($urandom_range(0, 7));
            r  = (n == 0) || ($urandom_range(0, 199) == 0);
            e_we = 0; e_re = 0; e_addr = 0; e_wd = 0; e_rdv = 0; e_pcl = 0; e_fll = 0; e_err = 0;
            e_busy = (pend != 0);
            if (r) begin
                stk.delete(); pend = 0; m_rd = 0; m_pc = 0; m_fl = 0;
            end else if (pend == 1) begin
                e_we = 1; e_addr = p_addr; e_wd = p_data; pend = 0;
            end else if (pend == 2) begin
                e_re = 1; e_addr = p_addr; e_pcl = 1; e_fll = 1; m_pc = rti_pc; m_fl = rti_fl; pend = 0;
            end else if (v) begin
                d = stk.size();
                spv = 32'(2046 - 2 * d);
                case (op)
                    LDD: begin e_re = 1; e_addr = a; m_rd = dm.exists(a) ? dm[a] : 32'd0; e_rdv = 1; end
                    STD: begin e_we = 1; e_addr = a; e_wd = wd; dm[a] = wd; end
                    PUSH, CALL: if (d <= 511) begin
                        e_we = 1; e_addr = spv; e_wd = (op == PUSH) ? wd : pc; stk.push_back(e_wd);
                    end else e_err = 1;
                    POP, RET: if (d >= 1) begin
                        e_re = 1; e_addr = spv + 2; tmp = stk.pop_back();
                        if (op == POP) begin m_rd = tmp; e_rdv = 1; end else begin m_pc = tmp; e_pcl = 1; end
                    end else e_err = 1;
                    INT: if (d <= 510) begin
                        e_we = 1; e_addr = spv; e_wd = pc;
                        stk.push_back(pc); stk.push_back({29'd0, fl});
                        pend = 1; p_addr = spv - 2; p_data = {29'd0, fl};
                    end else e_err = 1;
                    RTI: if (d >= 2) begin
                        e_re = 1; e_addr = spv + 2;
                        tmp = stk.pop_back(); rti_fl = tmp[2:0]; rti_pc = stk.pop_back();
                        pend = 2; p_addr = spv + 4;
                    end else e_err = 1;
                    default: ;
                endcase
            end
            e_sp = 32'(2046 - 2 * stk.size());
            tick(v, op, a, wd, pc, fl, r);
            n_vec++; if (c_we !== e_we) begin n_err++; $display("FAIL rnd_we[%0d]: got %0b want %0b", n, c_we, e_we); end
            n_vec++; if (c_re !== e_re) begin n_err++; $display("FAIL rnd_re[%0d]: got %0b want %0b", n, c_re, e_re); end
            n_vec++; if (c_addr !== e_addr) begin n_err++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, c_addr, e_addr); end
            n_vec++; if (c_wd !== e_wd) begin n_err++; $display("FAIL rnd_wdata[%0d]: got %h want %h", n, c_wd, e_wd); end
            n_vec++; if (c_busy !== e_busy) begin n_err++; $display("FAIL rnd_busy[%0d]: got %0b want %0b", n, c_busy, e_busy); end
            n_vec++; if ({q_rd_valid, q_pc_load, q_fl_load, q_err} !== {e_rdv, e_pcl, e_fll, e_err}) begin
                n_err++; $display("FAIL rnd_pulses[%0d]: got %b want %b", n,
                                  {q_rd_valid, q_pc_load, q_fl_load, q_err}, {e_rdv, e_pcl, e_fll, e_err}); end
            n_vec++; if (q_rd_data !== m_rd) begin n_err++; $display("FAIL rnd_rd_data[%0d]: got %h want %h", n, q_rd_data, m_rd); end
            n_vec++; if (q_pc_out !== m_pc) begin n_err++; $display("FAIL rnd_pc_out[%0d]: got %h want %h", n, q_pc_out, m_pc); end
            n_vec++; if (q_fl_out !== m_fl) begin n_err++; $display("FAIL rnd_flags[%0d]: got %b want %b", n, q_fl_out, m_fl); end
            n_vec++; if (q_sp !== e_sp) begin n_err++; $display("FAIL rnd_sp[%0d]: got %0d want %0d", n, q_sp, e_sp); end
            n_vec++; if (q_busy !== (pend != 0)) begin
                n_err++; $display("FAIL rnd_busy_next[%0d]: got %0b want %0b", n, q_busy, (pend != 0)); end
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_std_ldd();
        test_int_rti();
        test_underflow();
        test_overflow();
        test_back_to_back();
        test_reset_mid_rti();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stack_mem_controller.md
Name: stack_mem_controller

Overview:
- MEM-stage initiator that drives the data/stack memory port: enables, address and 32-bit write data.
- Owns the stack pointer (SP) and decodes the memory operations LDD, STD, PUSH, POP, CALL, RET, INT and RTI into one or two memory accesses.
- Sequences the two-access operations (INT, RTI) with a small FSM and stalls upstream while it does so.
- Returns registered read data, PC and flag values to write-back and fetch.

Parameters:
- data_width, 16, memory word width; each access moves 2 words (32 bits).
- address_width, 32, memory address width.
- num_of_register, 11, log2 of memory depth in words (2048 words).
- stack_floor, 1024, lowest word address the stack may write.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  operation request this cycle.
- op_code  in  4  NOP=0, LDD=1, STD=2, PUSH=3, POP=4, CALL=5, RET=6, INT=7, RTI=8; others are treated as NOP.
- ea  in  address_width  effective address for LDD/STD.
- wdata  in  2*data_width  store/push data.
- pc_in  in  2*data_width  return PC for CALL/INT.
- flags_in  in  3  CCR flags for INT.
- busy  out  1  high while in a second-access state; upstream holds its op.
- mem_write_enable  out  1  to memory write_enable.
- mem_read_enable  out  1  to memory read_enable.
- mem_address  out  address_width  to memory address.
- mem_write_data  out  2*data_width  to memory write_data.
- mem_read_data  in  2*data_width  from memory read_data (combinational).
- rd_data  out  2*data_width  registered LDD/POP result.
- rd_valid  out  1  one-cycle pulse with rd_data.
- pc_out  out  2*data_width  registered PC popped by RET/RTI.
- pc_load  out  1  one-cycle pulse with pc_out.
- flags_out  out  3  registered flags restored by RTI.
- flags_load  out  1  one-cycle pulse with flags_out.
- sp  out  address_width  current SP.
- stack_err  out  1  one-cycle pulse when a stack op is rejected.

Behaviour:
- Reset:
  - SP = 2**num_of_register-2 (2046); FSM = IDLE.
  - All pulses, busy, rd_data, pc_out and flags_out are 0.
  - Memory enables are forced 0 during any cycle with rst=1.
- Stack convention: descending; SP addresses the next free 32-bit slot.
  - Push: write at SP, then SP <= SP-2.
  - Pop: read at SP+2, then SP <= SP+2.
- Acceptance: an op is accepted when op_valid and not busy. op_valid while busy is ignored (no access, no state change).
- Memory drive: enables, address and write data are combinational from the accepted op or FSM state, so the access happens in the same cycle. When idle, enables are 0, address is 0 and write data is 0.
- Single-access ops; each completes in one cycle and any result is registered at the edge and pulsed the next cycle:
  - LDD: read at ea → rd_data/rd_valid.
  - STD: write wdata at ea.
  - PUSH: write wdata.
  - POP: read → rd_data/rd_valid.
  - CALL: write pc_in.
  - RET: read → pc_out/pc_load.
- INT: accept cycle writes pc_in at SP; FSM → INT_FLAGS with busy=1. That cycle writes {29'b0, flags_in} (latched at accept) at SP-2. SP ends at SP-4; FSM → IDLE.
- RTI: accept cycle reads at SP+2 and latches the flags; FSM → RTI_PC with busy=1. That cycle reads the PC at SP+4. SP ends at SP+4. pc_load and flags_load pulse together in the cycle after RTI_PC.
- FSM: IDLE → INT_FLAGS → IDLE, and IDLE → RTI_PC → IDLE. No other transitions; an unreachable state code recovers to IDLE.
- Overflow (full): a push-type op is rejected if SP < stack_floor; INT is rejected if SP-2 < stack_floor. On rejection: no memory access, SP unchanged, stack_err pulses the next cycle.
- Underflow (empty): POP/RET is rejected if SP == 2046; RTI is rejected if SP > 2042. Handling is the same as overflow.
- Checks for two-access ops are made at accept, so an op either completes fully or has no effect.
- Reset mid-INT/RTI: the second access is abandoned and the registered reset values apply.
- Arithmetic: SP arithmetic is modulo 2**address_width. LDD/STD at odd ea are permitted and passed through unchanged.

Decomposition:
- Shared package mem_pkg holds:
  - op_code constants;
  - state encoding (IDLE, INT_FLAGS, RTI_PC);
  - the reset-SP and stack_floor defaults.
- Natural sub-module: stack_pointer_unit, holding the SP register, the ±2/±4 update, and the full/empty compare.

Test Plan:
- Reset, then PUSH wdata=0xDEADBEEF → write at 2046 with data 0xDEADBEEF; sp=2044. A following POP reads 2046, rd_data=0xDEADBEEF with rd_valid one cycle later, and sp=2046.
- STD ea=0x10 wdata=0x12345678, then LDD ea=0x10 → rd_data=0x12345678. SP stays 2046 throughout.
- INT with pc_in=0x00000100, flags_in=3'b101 → busy for 1 cycle; writes 0x100@2046 then 0x5@2044; sp=2042. RTI then gives pc_out=0x100 and flags_out=101 pulsing together; sp=2046.
- POP at reset SP → stack_err pulse, no read enable, sp=2046. With stack_floor=2044, two PUSHes then a third → third rejected, sp=2042.
- op_valid=1 with op_code=PUSH held during the INT_FLAGS cycle → ignored. The held PUSH is accepted the following cycle, giving exactly one extra write.
- rst asserted in RTI_PC → no pc_load; next cycle sp=2046, busy=0, enables 0.
